// File: rtl/datapath_issue_arbiter_pkg.sv
// Shared types and defaults for the datapath issue arbiter.
// Arbiter state encoding and requester index constants.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic SRC_RQ0 = 1'b0;
  localparam logic SRC_RQ1 = 1'b1;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_CTRL2_W = 2;
  localparam int DEF_TIMEOUT = 8;
  localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/datapath_issue_arbiter_slot.sv
// One-deep issue slot feeding the datapath pipeline stage.
// Holds valid, fields and source index; loads only when enabled.
module issue_slot_reg
  import arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL2_W = DEF_CTRL2_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_valid,
  input  logic               i_ctrl1,
  input  logic [CTRL2_W-1:0] i_ctrl2,
  input  logic [DATA_W-1:0]  i_data1,
  input  logic [DATA_W-1:0]  i_data2,
  input  logic               i_src,
  output logic               o_valid,
  output logic               o_ctrl1,
  output logic [CTRL2_W-1:0] o_ctrl2,
  output logic [DATA_W-1:0]  o_data1,
  output logic [DATA_W-1:0]  o_data2,
  output logic               o_src
);

  logic               r_valid;
  logic               r_ctrl1;
  logic [CTRL2_W-1:0] r_ctrl2;
  logic [DATA_W-1:0]  r_data1;
  logic [DATA_W-1:0]  r_data2;
  logic               r_src;

  // Slot register: valid follows every load, fields only take real beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl1 <= 1'b0;
      r_ctrl2 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_src   <= SRC_RQ0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_ctrl1 <= i_ctrl1;
        r_ctrl2 <= i_ctrl2;
        r_data1 <= i_data1;
        r_data2 <= i_data2;
        r_src   <= i_src;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl1 = r_ctrl1;
  assign o_ctrl2 = r_ctrl2;
  assign o_data1 = r_data1;
  assign o_data2 = r_data2;
  assign o_src   = r_src;

endmodule

// File: rtl/datapath_issue_arbiter.sv
// Two-requester burst arbiter sharing one issue slot.
// Round-robin at burst edges, owner lock, stall watchdog.
module datapath_issue_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL2_W = DEF_CTRL2_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rq0_valid,
  output logic               rq0_ready,
  input  logic               rq0_last,
  input  logic               rq0_ctrl1,
  input  logic [CTRL2_W-1:0] rq0_ctrl2,
  input  logic [DATA_W-1:0]  rq0_data1,
  input  logic [DATA_W-1:0]  rq0_data2,
  input  logic               rq1_valid,
  output logic               rq1_ready,
  input  logic               rq1_last,
  input  logic               rq1_ctrl1,
  input  logic [CTRL2_W-1:0] rq1_ctrl2,
  input  logic [DATA_W-1:0]  rq1_data1,
  input  logic [DATA_W-1:0]  rq1_data2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_ctrl1,
  output logic [CTRL2_W-1:0] out_ctrl2,
  output logic [DATA_W-1:0]  out_data1,
  output logic [DATA_W-1:0]  out_data2,
  output logic               out_src,
  output logic               timeout_err
);

  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr;
  logic             w_rr_nxt;
  logic [CNT_W-1:0] r_wd;
  logic [CNT_W-1:0] w_wd_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic w_load_en;
  logic w_sel;
  logic w_rdy0;
  logic w_rdy1;
  logic w_sel_valid;
  logic w_sel_last;
  logic w_xfer;

  assign w_load_en = !out_valid || out_ready;

  // Grant: pick the requester this cycle and raise its ready.
  always_comb begin
    w_sel  = SRC_RQ0;
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rq0_valid && rq1_valid) begin
          w_sel = r_rr;
        end else begin
          w_sel = rq1_valid ? SRC_RQ1 : SRC_RQ0;
        end
        if (rq0_valid || rq1_valid) begin
          w_rdy0 = (w_sel == SRC_RQ0) && w_load_en;
          w_rdy1 = (w_sel == SRC_RQ1) && w_load_en;
        end
      end
      OWN0: begin
        w_sel  = SRC_RQ0;
        w_rdy0 = w_load_en;
      end
      OWN1: begin
        w_sel  = SRC_RQ1;
        w_rdy1 = w_load_en;
      end
      default: begin
        w_sel = SRC_RQ0;
      end
    endcase
  end

  assign rq0_ready   = w_rdy0 && reset;
  assign rq1_ready   = w_rdy1 && reset;
  assign w_sel_valid = w_sel ? rq1_valid : rq0_valid;
  assign w_sel_last  = w_sel ? rq1_last : rq0_last;
  assign w_xfer      = w_sel ? (rq1_valid && rq1_ready)
                             : (rq0_valid && rq0_ready);

  // Next state: burst ownership, round-robin pointer, watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_wd_nxt    = r_wd;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (w_sel_last) begin
            w_rr_nxt = !w_sel;
          end else begin
            w_state_nxt = w_sel ? OWN1 : OWN0;
            w_wd_nxt    = '0;
          end
        end
      end
      OWN0, OWN1: begin
        if (w_xfer && w_sel_last) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = !w_sel;
          w_wd_nxt    = '0;
        end else if (w_sel_valid) begin
          w_wd_nxt = '0;
        end else if (r_wd == TO_M1) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = !w_sel;
          w_wd_nxt    = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rr    <= SRC_RQ0;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_wd    <= w_wd_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign timeout_err = r_err;

  issue_slot_reg #(
    .DATA_W  (DATA_W),
    .CTRL2_W (CTRL2_W)
  ) u_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_load_en),
    .i_valid (w_xfer),
    .i_ctrl1 (w_sel ? rq1_ctrl1 : rq0_ctrl1),
    .i_ctrl2 (w_sel ? rq1_ctrl2 : rq0_ctrl2),
    .i_data1 (w_sel ? rq1_data1 : rq0_data1),
    .i_data2 (w_sel ? rq1_data2 : rq0_data2),
    .i_src   (w_sel),
    .o_valid (out_valid),
    .o_ctrl1 (out_ctrl1),
    .o_ctrl2 (out_ctrl2),
    .o_data1 (out_data1),
    .o_data2 (out_data2),
    .o_src   (out_src)
  );

endmodule

// File: tb/tb_datapath_issue_arbiter.sv
// Bench for datapath_issue_arbiter: directed scenarios plus random
// traffic, checked each cycle against a behavioural model.
module tb_datapath_issue_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rq0_valid = 0, rq0_last = 0, rq0_ctrl1 = 0;
  logic [1:0] rq0_ctrl2 = 0;
  logic [3:0] rq0_data1 = 0, rq0_data2 = 0;
  logic       rq1_valid = 0, rq1_last = 0, rq1_ctrl1 = 0;
  logic [1:0] rq1_ctrl2 = 0;
  logic [3:0] rq1_data1 = 0, rq1_data2 = 0;
  logic       rq0_ready, rq1_ready;
  logic       out_valid, out_ready = 1'b1;
  logic       out_ctrl1, out_src, timeout_err;
  logic [1:0] out_ctrl2;
  logic [3:0] out_data1, out_data2;

  typedef struct {
    int       gap;
    bit       last;
    bit       c1;
    bit [1:0] c2;
    bit [3:0] d1;
    bit [3:0] d2;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  bit    pres0, pres1, acc0, acc1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_to    = 0;
  int log_q[$];
  int exp_q[$];

  // behavioural model: owner -1 means no burst in progress
  int       m_own = -1;
  int       m_rr = 0;
  int       m_idle = 0;
  bit       m_ov = 0;
  bit       m_err = 0;
  int       m_src = 0;
  bit       m_c1 = 0;
  bit [1:0] m_c2 = 0;
  bit [3:0] m_d1 = 0;
  bit [3:0] m_d2 = 0;

  always #5 clk = ~clk;

  datapath_issue_arbiter #(
    .DATA_W(4), .CTRL2_W(2), .TIMEOUT(TO), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_last(rq0_last),
    .rq0_ctrl1(rq0_ctrl1), .rq0_ctrl2(rq0_ctrl2),
    .rq0_data1(rq0_data1), .rq0_data2(rq0_data2),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_last(rq1_last),
    .rq1_ctrl1(rq1_ctrl1), .rq1_ctrl2(rq1_ctrl2),
    .rq1_data1(rq1_data1), .rq1_data2(rq1_data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl1(out_ctrl1), .out_ctrl2(out_ctrl2),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_src(out_src), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // requester 0 driver: honours gaps, holds a beat until accepted
  always @(negedge clk) begin
    if (acc0 && q0.size() > 0) begin
      q0.delete(0);
      pres0 = 0;
    end
    if (q0.size() == 0) begin
      pres0 = 0;
      rq0_valid = 0;
    end else if (!pres0 && q0[0].gap > 0) begin
      q0[0].gap = q0[0].gap - 1;
      rq0_valid = 0;
    end else begin
      pres0 = 1;
      rq0_valid = 1;
      rq0_last = q0[0].last;
      rq0_ctrl1 = q0[0].c1;
      rq0_ctrl2 = q0[0].c2;
      rq0_data1 = q0[0].d1;
      rq0_data2 = q0[0].d2;
    end
  end

  // requester 1 driver
  always @(negedge clk) begin
    if (acc1 && q1.size() > 0) begin
      q1.delete(0);
      pres1 = 0;
    end
    if (q1.size() == 0) begin
      pres1 = 0;
      rq1_valid = 0;
    end else if (!pres1 && q1[0].gap > 0) begin
      q1[0].gap = q1[0].gap - 1;
      rq1_valid = 0;
    end else begin
      pres1 = 1;
      rq1_valid = 1;
      rq1_last = q1[0].last;
      rq1_ctrl1 = q1[0].c1;
      rq1_ctrl2 = q1[0].c2;
      rq1_data1 = q1[0].d1;
      rq1_data2 = q1[0].d2;
    end
  end

  // compare process: check outputs, predict readies, advance model
  always begin
    int  win;
    bit  le, xv, bl, ov;
    @(negedge clk);
    #2;
    if (!reset) begin
      m_own = -1; m_rr = 0; m_idle = 0; m_ov = 0; m_err = 0;
      m_src = 0; m_c1 = 0; m_c2 = 0; m_d1 = 0; m_d2 = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_bits", int'({out_ctrl1, out_ctrl2, out_data1,
                                out_data2, out_src}), 0);
      chk("rst_err", int'(timeout_err), 0);
      chk("rst_rdy", int'({rq0_ready, rq1_ready}), 0);
      acc0 = 0;
      acc1 = 0;
    end else begin
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_ov) begin
        chk("out_src", int'(out_src), m_src);
        chk("out_ctrl1", int'(out_ctrl1), int'(m_c1));
        chk("out_ctrl2", int'(out_ctrl2), int'(m_c2));
        chk("out_data1", int'(out_data1), int'(m_d1));
        chk("out_data2", int'(out_data2), int'(m_d2));
      end
      chk("timeout_err", int'(timeout_err), int'(m_err));
      if (timeout_err) n_to++;
      if (out_valid && out_ready)
        log_q.push_back(int'(out_src) * 16 + int'(out_data1));
      le = !m_ov || out_ready;
      if (m_own >= 0) win = m_own;
      else if (rq0_valid && rq1_valid) win = m_rr;
      else if (rq0_valid) win = 0;
      else if (rq1_valid) win = 1;
      else win = -1;
      chk("rq0_ready", int'(rq0_ready), int'(win == 0 && le));
      chk("rq1_ready", int'(rq1_ready), int'(win == 1 && le));
      acc0 = rq0_valid && rq0_ready;
      acc1 = rq1_valid && rq1_ready;
      ov = (win == 1) ? rq1_valid : (win == 0) ? rq0_valid : 1'b0;
      bl = (win == 1) ? rq1_last : rq0_last;
      xv = ov && le;
      m_err = 0;
      if (le) begin
        m_ov = xv;
        if (xv) begin
          m_src = win;
          m_c1 = (win == 1) ? rq1_ctrl1 : rq0_ctrl1;
          m_c2 = (win == 1) ? rq1_ctrl2 : rq0_ctrl2;
          m_d1 = (win == 1) ? rq1_data1 : rq0_data1;
          m_d2 = (win == 1) ? rq1_data2 : rq0_data2;
        end
      end
      if (m_own < 0) begin
        if (xv) begin
          if (bl) m_rr = 1 - win;
          else begin
            m_own = win;
            m_idle = 0;
          end
        end
      end else if (xv && bl) begin
        m_rr = 1 - m_own;
        m_own = -1;
        m_idle = 0;
      end else if (ov) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle >= TO) begin
          m_rr = 1 - m_own;
          m_own = -1;
          m_idle = 0;
          m_err = 1;
        end
      end
    end
  end

  task automatic push(input int n, input int gap, input bit last,
                      input int d1);
    beat_t b;
    b.gap = gap;
    b.last = last;
    b.c1 = 1'($urandom_range(0, 1));
    b.c2 = 2'($urandom_range(0, 3));
    b.d1 = 4'(d1);
    b.d2 = 4'($urandom_range(0, 15));
    if (n == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic push_rnd(input int n);
    int g;
    if ($urandom_range(0, 7) == 0) g = $urandom_range(6, 12);
    else g = $urandom_range(0, 2);
    push(n, g, $urandom_range(0, 2) == 0, $urandom_range(0, 15));
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || out_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d cycles required < 300", nm, k);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_order%0d", nm, i), log_q[i], exp_q[i]);
  endtask

  initial begin
    int to0;
    repeat (2) @(negedge clk);
    #3;
    chk("lit_rst_valid", int'(out_valid), 0);
    chk("lit_rst_data1", int'(out_data1), 0);
    @(negedge clk);
    reset = 1;

    // alternating single-beat bursts
    log_q.delete();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 1, 1 + i);
      push(1, 0, 1, 9 + i);
    end
    exp_q = '{1, 25, 2, 26, 3, 27};
    drain("s1");
    check_log("s1");

    // rq0 three-beat burst locks out rq1
    log_q.delete();
    @(posedge clk);
    push(0, 0, 0, 4);
    push(0, 0, 0, 5);
    push(0, 0, 1, 6);
    push(1, 0, 1, 12);
    push(1, 0, 1, 13);
    exp_q = '{4, 5, 6, 28, 29};
    drain("s2");
    check_log("s2");

    // downstream stall with the slot full
    log_q.delete();
    @(negedge clk);
    out_ready = 0;
    @(posedge clk);
    push(0, 0, 1, 7);
    push(0, 0, 1, 8);
    repeat (5) @(negedge clk);
    #3;
    chk("lit_stall_valid", int'(out_valid), 1);
    chk("lit_stall_data1", int'(out_data1), 7);
    chk("lit_stall_rdy0", int'(rq0_ready), 0);
    @(negedge clk);
    out_ready = 1;
    exp_q = '{7, 8};
    drain("s3");
    check_log("s3");

    // owner rq1 stalls mid-burst until the watchdog fires
    log_q.delete();
    to0 = n_to;
    @(posedge clk);
    push(1, 0, 0, 1);
    push(1, 20, 1, 2);
    push(0, 2, 1, 3);
    exp_q = '{17, 3, 18};
    drain("s4");
    check_log("s4");
    chk("lit_timeout_pulses", n_to - to0, 1);

    // owner returns on the cycle the watchdog would expire
    log_q.delete();
    to0 = n_to;
    @(posedge clk);
    push(1, 0, 0, 5);
    push(1, 7, 1, 6);
    exp_q = '{21, 22};
    drain("s5");
    check_log("s5");
    chk("lit_no_timeout", n_to - to0, 0);

    // reset mid-burst with the slot full
    @(negedge clk);
    out_ready = 0;
    @(posedge clk);
    push(0, 0, 0, 1);
    push(0, 0, 0, 2);
    push(0, 0, 1, 3);
    repeat (3) @(negedge clk);
    reset = 0;
    q0.delete();
    q1.delete();
    #3;
    chk("lit_midrst_valid", int'(out_valid), 0);
    chk("lit_midrst_data1", int'(out_data1), 0);
    chk("lit_midrst_rdy0", int'(rq0_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    out_ready = 1;
    log_q.delete();
    @(posedge clk);
    push(0, 0, 1, 14);
    push(1, 0, 1, 15);
    exp_q = '{14, 31};
    drain("s6");
    check_log("s6");

    // random traffic with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (c == 700) begin
        reset = 0;
        q0.delete();
        q1.delete();
      end
      if (c == 702) reset = 1;
      if (q0.size() < 2) push_rnd(0);
      if (q1.size() < 2) push_rnd(1);
    end
    @(negedge clk);
    out_ready = 1;
    drain("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
